// File: rtl/sp_sram.sv
// sp_sram: single-port SRAM with cen/wen/oen; define SPSRAM_ASYNC_READ_EN for a combinational read path
module sp_sram #(
    parameter int BW_DATA = 32,
    parameter int BW_ADDR = 10
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    output logic [BW_DATA-1:0] o_data,
    input  logic [BW_DATA-1:0] i_data,
    input  logic [BW_ADDR-1:0] i_addr,
    input  logic               i_wen,
    input  logic               i_cen,
    input  logic               i_oen
);
    logic [BW_DATA-1:0] mem [2**BW_ADDR];
    always_ff @(posedge i_clk)
        if (i_rstn && i_cen && i_wen) mem[i_addr] <= i_data;
`ifdef SPSRAM_ASYNC_READ_EN
    assign o_data = (i_cen && i_oen) ? mem[i_addr] : '0;
`else
    logic [BW_DATA-1:0] rd_q;
    always_ff @(posedge i_clk)
        if (!i_rstn) rd_q <= '0;
        else if (i_cen && !i_wen && i_oen) rd_q <= mem[i_addr];
    assign o_data = i_oen ? rd_q : '0;
`endif
endmodule

// File: tb/tb_sp_sram.sv
// tb_sp_sram: randomized and directed checks of sp_sram (registered read) against a word-array model
module tb_sp_sram;
    localparam int DEPTH = 1024;
    logic        clk = 1'b0;
    logic        rstn, wen, cen, oen;
    logic [31:0] data, q;
    logic [9:0]  addr;
    logic [5:0]  b_addr;
    logic [31:0] b_data;
    logic        b_wen;
    logic [31:0] b_q [4];
    logic [31:0] m [DEPTH];
    logic [31:0] rd;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    sp_sram dut (
        .i_clk(clk), .i_rstn(rstn), .o_data(q), .i_data(data),
        .i_addr(addr), .i_wen(wen), .i_cen(cen), .i_oen(oen)
    );

    for (genvar g = 0; g < 4; g++) begin : g_bank
        sp_sram #(.BW_DATA(32), .BW_ADDR(6)) bank (
            .i_clk(clk), .i_rstn(rstn), .o_data(b_q[g]), .i_data(b_data),
            .i_addr(b_addr), .i_wen(b_wen), .i_cen(b_addr[5:4] == 2'(g)),
            .i_oen(!b_wen && b_addr[5:4] == 2'(g))
        );
    end

    // drive one cycle, advance past the edge and keep the model in step
    task automatic op(input logic r, input logic c, input logic w, input logic o,
                      input logic [9:0] a, input logic [31:0] d);
        rstn = r; cen = c; wen = w; oen = o; addr = a; data = d;
        @(posedge clk);
        #1;
        if (!r) rd = '0;
        else if (c && w) m[a] = d;
        else if (c && o) rd = m[a];
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            op(1'b0, 1'b1, 1'b1, 1'b1, 10'd5, 32'hAA);
            n_checks++;
            if (q !== 32'h0) begin n_fail++; $display("FAIL reset_q got %h want 0", q); end
        end
        op(1'b1, 1'b0, 1'b0, 1'b1, 10'd0, 32'h0);
        n_checks++;
        if (q !== 32'h0) begin n_fail++; $display("FAIL post_reset_q got %h want 0", q); end
        op(1'b1, 1'b1, 1'b0, 1'b1, 10'd5, 32'h0);
        n_checks++;
        if (q === 32'hAA) begin n_fail++; $display("FAIL reset_write got %h want not 000000aa", q); end
    endtask

    task automatic test_fill;
        for (int i = 0; i < DEPTH; i++) op(1'b1, 1'b1, 1'b1, 1'b0, 10'(i), 32'(i));
        for (int i = 0; i < DEPTH; i++) begin
            op(1'b1, 1'b1, 1'b0, 1'b1, 10'(i), 32'hDEAD);
            n_checks++;
            if (q !== 32'(i)) begin n_fail++; $display("FAIL fill_read addr %0d got %h want %h", i, q, 32'(i)); end
        end
        for (int i = 0; i < 64; i++) begin
            automatic logic [9:0] a = 10'($urandom);
            op(1'b1, 1'b1, 1'b0, 1'b1, a, 32'h0);
            n_checks++;
            if (q !== 32'(a)) begin n_fail++; $display("FAIL rand_read addr %0d got %h want %h", a, q, 32'(a)); end
        end
    endtask

    task automatic test_cen;
        op(1'b1, 1'b1, 1'b1, 1'b0, 10'd3, 32'h55);
        op(1'b1, 1'b0, 1'b1, 1'b0, 10'd3, 32'h77);
        op(1'b1, 1'b1, 1'b0, 1'b1, 10'd3, 32'h0);
        n_checks++;
        if (q !== 32'h55) begin n_fail++; $display("FAIL cen_write got %h want 00000055", q); end
        op(1'b1, 1'b0, 1'b0, 1'b1, 10'd10, 32'h0);
        n_checks++;
        if (q !== 32'h55) begin n_fail++; $display("FAIL cen_read_hold got %h want 00000055", q); end
    endtask

    task automatic test_oen;
        oen = 1'b0;
        #1;
        n_checks++;
        if (q !== 32'h0) begin n_fail++; $display("FAIL oen_low got %h want 0", q); end
        op(1'b1, 1'b1, 1'b0, 1'b0, 10'd20, 32'h0);
        n_checks++;
        if (q !== 32'h0) begin n_fail++; $display("FAIL oen_low_edge got %h want 0", q); end
        cen = 1'b0; oen = 1'b1;
        #1;
        n_checks++;
        if (q !== 32'h55) begin n_fail++; $display("FAIL oen_restore got %h want 00000055", q); end
    endtask

    task automatic test_write_priority;
        op(1'b1, 1'b1, 1'b1, 1'b1, 10'd7, 32'h1234);
        n_checks++;
        if (q !== 32'h55) begin n_fail++; $display("FAIL wp_hold got %h want 00000055", q); end
        op(1'b1, 1'b1, 1'b0, 1'b1, 10'd7, 32'h0);
        n_checks++;
        if (q !== 32'h1234) begin n_fail++; $display("FAIL wp_read got %h want 00001234", q); end
        op(1'b1, 1'b1, 1'b1, 1'b1, 10'd7, 32'hBEEF);
        n_checks++;
        if (q !== 32'h1234) begin n_fail++; $display("FAIL rdw_hold got %h want 00001234", q); end
        op(1'b1, 1'b1, 1'b0, 1'b1, 10'd7, 32'h0);
        n_checks++;
        if (q !== 32'hBEEF) begin n_fail++; $display("FAIL rdw_read got %h want 0000beef", q); end
    endtask

    task automatic test_banking;
        b_wen = 1'b1;
        for (int i = 0; i < 64; i++) begin
            b_addr = 6'(i); b_data = 32'(i);
            @(posedge clk);
            #1;
        end
        b_wen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            b_addr = 6'(i);
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                automatic logic [31:0] exp = (i / 16 == k) ? 32'(i) : 32'h0;
                n_checks++;
                if (b_q[k] !== exp) begin n_fail++; $display("FAIL bank%0d addr %0d got %h want %h", k, i, b_q[k], exp); end
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            automatic logic o = 1'($urandom);
            op(($urandom % 16) != 0, 1'($urandom), 1'($urandom), o, 10'($urandom % 16), $urandom);
            n_checks++;
            if (q !== (o ? rd : 32'h0)) begin
                n_fail++; $display("FAIL random step %0d got %h want %h", i, q, o ? rd : 32'h0);
            end
        end
    endtask

    initial begin
        rstn = 1'b0; cen = 1'b0; wen = 1'b0; oen = 1'b0; addr = '0; data = '0;
        b_addr = '0; b_data = '0; b_wen = 1'b0; rd = '0;
        test_reset;
        test_fill;
        test_cen;
        test_oen;
        test_write_priority;
        test_banking;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
